// File: rtl/dlc_tx_mac_pkg.sv
// dlc_tx_mac_pkg: shared definitions for the DLC transmit MAC.
//   state_t      - transmit controller states (3-bit encoding)
//   BACKOFF_CAP  - ceiling on the backoff exponent
//   LFSR_SEED    - reset value of the backoff LFSR
//   lfsr_next    - one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   backoff_mask - (1 << min(n, BACKOFF_CAP)) - 1
package dlc_tx_mac_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    WAIT_IB     = 3'd2,
    SEND        = 3'd3,
    WAIT_RESULT = 3'd4,
    COLLIDE     = 3'd5,
    BACKOFF     = 3'd6
  } state_t;

  localparam int unsigned BACKOFF_CAP = 10;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // The bit loop caps the exponent at BACKOFF_CAP without a separate min().
  function automatic logic [BACKOFF_CAP-1:0] backoff_mask(input int unsigned attempts);
    logic [BACKOFF_CAP-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BACKOFF_CAP; i++) begin
      if (i < attempts) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dlc_tx_buffer.sv
// dlc_tx_buffer: MAX_LEN x 8 frame buffer, single write port, registered read.
//   clk, reset          - clock; reset clears only the read register
//   wr_en/wr_addr/wr_data
//   rd_en/rd_addr       - rd_data updates on the edge where rd_en is high
//   rd_data             - registered read data (drives D_TX directly)
module dlc_tx_buffer #(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dlc_tx_mac.sv
// dlc_tx_mac: DLC-side transmit controller for one PHY channel.
// Buffers one frame, waits for IFG_CYCLES of idle bus, paces bytes to the PHY
// one per BYTE_PERIOD cycles, and retries collisions with truncated binary
// exponential backoff up to MAX_ATTEMPTS attempts.
// Ports:
//   clk_40mhz, reset (sync, active high)
//   up_data/up_valid/up_last/up_ready - packet source byte stream
//   D_TX/D_TX_ready                   - byte and one-cycle strobe to the PHY
//   CD, TX_success, IB                - PHY collision, success, idle bus
//   tx_done/tx_fail                   - one-cycle frame outcome pulses
//   busy                              - controller not in IDLE
// Optional: define DLC_TX_STATS_EN to add saturating counters
//   frames_ok, frames_failed, collisions.
module dlc_tx_mac
  import dlc_tx_mac_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 256,
  parameter int unsigned BYTE_PERIOD    = 20,
  parameter int unsigned IFG_CYCLES     = 40,
  parameter int unsigned SLOT_CYCLES    = 512,
  parameter int unsigned MAX_ATTEMPTS   = 16,
  parameter int unsigned RESULT_TIMEOUT = 200
) (
  input  logic        clk_40mhz,
  input  logic        reset,
  input  logic [7:0]  up_data,
  input  logic        up_valid,
  input  logic        up_last,
  output logic        up_ready,
  output logic [7:0]  D_TX,
  output logic        D_TX_ready,
  input  logic        CD,
  input  logic        TX_success,
  input  logic        IB,
  output logic        tx_done,
  output logic        tx_fail,
  output logic        busy
`ifdef DLC_TX_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_failed,
  output logic [15:0] collisions
`endif
);

  localparam int unsigned AW  = $clog2(MAX_LEN);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned PW  = $clog2(BYTE_PERIOD + 1);
  localparam int unsigned IW  = $clog2(IFG_CYCLES + 1);
  localparam int unsigned RW  = $clog2(RESULT_TIMEOUT + 1);
  localparam int unsigned ATW = $clog2(MAX_ATTEMPTS) + 1;
  localparam int unsigned BW  = $clog2(((2 ** BACKOFF_CAP) - 1) * SLOT_CYCLES + 1);

  state_t          state;
  logic [LW-1:0]   wr_ptr, rd_ptr, len, rd_ptr_inc;
  logic [PW-1:0]   pace;
  logic [IW-1:0]   idle_cnt;
  logic [RW-1:0]   res_cnt;
  logic [BW-1:0]   bo_cnt;
  logic [ATW-1:0]  attempt, attempt_n;
  logic [15:0]     lfsr;

  logic            accept, wr_full, start_tx, next_byte;
  logic            wr_en, rd_en;
  logic [AW-1:0]   wr_addr, rd_addr;

  assign busy       = (state != IDLE);
  assign accept     = up_valid && up_ready;
  assign wr_full    = (wr_ptr == LW'(MAX_LEN));
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign attempt_n  = attempt + 1'b1;

  // Buffer reads are issued on the same edge that raises D_TX_ready, so the
  // RAM output register is D_TX itself.
  assign start_tx  = (state == WAIT_IB) && IB && (idle_cnt == IW'(IFG_CYCLES - 1));
  assign next_byte = (state == SEND) && !CD && (pace == PW'(BYTE_PERIOD - 1));
  assign rd_en     = start_tx || next_byte;
  assign rd_addr   = start_tx ? '0 : rd_ptr_inc[AW-1:0];

  assign wr_en   = accept && ((state == IDLE) || ((state == LOAD) && !wr_full));
  assign wr_addr = (state == IDLE) ? '0 : wr_ptr[AW-1:0];

  dlc_tx_buffer #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk     (clk_40mhz),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (up_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (D_TX)
  );

  always_ff @(posedge clk_40mhz) begin
    if (reset) begin
      state      <= IDLE;
      up_ready   <= 1'b0;
      D_TX_ready <= 1'b0;
      tx_done    <= 1'b0;
      tx_fail    <= 1'b0;
      attempt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      len        <= '0;
      pace       <= '0;
      idle_cnt   <= '0;
      res_cnt    <= '0;
      bo_cnt     <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      lfsr       <= lfsr_next(lfsr);
      D_TX_ready <= 1'b0;
      tx_done    <= 1'b0;
      tx_fail    <= 1'b0;
      case (state)
        IDLE: begin
          up_ready <= 1'b1;
          if (accept) begin
            attempt <= '0;
            wr_ptr  <= LW'(1);
            // A single-byte frame completes on its first beat.
            if (up_last) begin
              len      <= LW'(1);
              up_ready <= 1'b0;
              idle_cnt <= '0;
              state    <= WAIT_IB;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (!wr_full) wr_ptr <= rd_ptr_inc - rd_ptr + wr_ptr;
            if (up_last) begin
              len      <= wr_full ? LW'(MAX_LEN) : wr_ptr + 1'b1;
              up_ready <= 1'b0;
              idle_cnt <= '0;
              state    <= WAIT_IB;
            end
          end
        end
        WAIT_IB: begin
          if (!IB) begin
            idle_cnt <= '0;
          end else if (start_tx) begin
            rd_ptr     <= '0;
            pace       <= '0;
            D_TX_ready <= 1'b1;
            state      <= SEND;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        SEND: begin
          if (CD) begin
            state <= COLLIDE;
          end else if ((pace == '0) && (rd_ptr == len - 1'b1)) begin
            res_cnt <= '0;
            state   <= WAIT_RESULT;
          end else if (next_byte) begin
            pace       <= '0;
            rd_ptr     <= rd_ptr_inc;
            D_TX_ready <= 1'b1;
          end else begin
            pace <= pace + 1'b1;
          end
        end
        WAIT_RESULT: begin
          if (CD) begin
            state <= COLLIDE;
          end else if (TX_success) begin
            tx_done  <= 1'b1;
            attempt  <= '0;
            wr_ptr   <= '0;
            up_ready <= 1'b1;
            state    <= IDLE;
          end else if (res_cnt == RW'(RESULT_TIMEOUT - 1)) begin
            state <= COLLIDE;
          end else begin
            res_cnt <= res_cnt + 1'b1;
          end
        end
        COLLIDE: begin
          if (attempt_n == ATW'(MAX_ATTEMPTS)) begin
            tx_fail  <= 1'b1;
            attempt  <= '0;
            wr_ptr   <= '0;
            up_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            attempt <= attempt_n;
            bo_cnt  <= BW'(lfsr[BACKOFF_CAP-1:0] & backoff_mask(32'(attempt_n)))
                       * BW'(SLOT_CYCLES);
            state   <= BACKOFF;
          end
        end
        BACKOFF: begin
          // A zero-slot backoff still spends its one cycle here.
          if (bo_cnt <= BW'(1)) begin
            idle_cnt <= '0;
            state    <= WAIT_IB;
          end else begin
            bo_cnt <= bo_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DLC_TX_STATS_EN
  always_ff @(posedge clk_40mhz) begin
    if (reset) begin
      frames_ok     <= '0;
      frames_failed <= '0;
      collisions    <= '0;
    end else begin
      if (tx_done && (frames_ok != '1))       frames_ok     <= frames_ok + 1'b1;
      if (tx_fail && (frames_failed != '1))   frames_failed <= frames_failed + 1'b1;
      if ((state == COLLIDE) && (collisions != '1)) collisions <= collisions + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dlc_tx_mac.sv
module tb_dlc_tx_mac;

  localparam int SLOT = 4;

  logic       clk, reset;
  logic [7:0] up_data;
  logic       up_valid, up_last, up_ready;
  logic [7:0] D_TX;
  logic       D_TX_ready, CD, TX_success, IB, tx_done, tx_fail, busy;
`ifdef DLC_TX_STATS_EN
  logic [15:0] frames_ok, frames_failed, collisions;
`endif

  dlc_tx_mac #(
    .MAX_LEN        (256),
    .BYTE_PERIOD    (20),
    .IFG_CYCLES     (40),
    .SLOT_CYCLES    (SLOT),
    .MAX_ATTEMPTS   (16),
    .RESULT_TIMEOUT (200)
  ) dut (
    .clk_40mhz  (clk),
    .reset      (reset),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_last    (up_last),
    .up_ready   (up_ready),
    .D_TX       (D_TX),
    .D_TX_ready (D_TX_ready),
    .CD         (CD),
    .TX_success (TX_success),
    .IB         (IB),
    .tx_done    (tx_done),
    .tx_fail    (tx_fail),
    .busy       (busy)
`ifdef DLC_TX_STATS_EN
    ,
    .frames_ok     (frames_ok),
    .frames_failed (frames_failed),
    .collisions    (collisions)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // kind: 0 = strobe, 1 = tx_done, 2 = tx_fail
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [15:0] lfsr_m;
  logic [7:0] fb [300];
  int         ready_wait = 0;

  // Cycle index and reference LFSR, both updated at every rising edge.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= reset ? 16'hACE1 : {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic check_out(input int kind, input logic [7:0] d);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_out: kind=%0d data=%02h cyc=%0d", kind, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data !== d || e.cyc != cyc) begin
        bad++;
        $display("FAIL out: got kind=%0d data=%02h cyc=%0d want kind=%0d data=%02h cyc=%0d",
                 kind, d, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every output event is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (D_TX_ready) check_out(0, D_TX);
    if (tx_done)    check_out(1, 8'h00);
    if (tx_fail)    check_out(2, 8'h00);
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    int guard = 0;
    up_valid = 1'b1;
    up_data  = d;
    up_last  = last;
    if (!up_ready) ready_wait++;
    while (!up_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!up_ready) begin
      total++;
      bad++;
      $display("FAIL up_ready_timeout: got 0 want 1 (cyc %0d)", cyc);
    end
    @(negedge clk);
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  // Returns the cycle on which the block enters WAIT_IB (after the last beat).
  task automatic push_frame(input int n, output int w);
    for (int i = 0; i < n; i++) push_byte(fb[i], (i == n - 1));
    w = cyc;
  endtask

  task automatic expect_strobes(input int w, input int n);
    for (int i = 0; i < n; i++) q.push_back('{0, fb[i], w + 40 + 20 * i});
  endtask

  task automatic success_at(input int t);
    q.push_back('{1, 8'h00, t + 1});
    wait_cyc(t);
    TX_success = 1'b1;
    @(negedge clk);
    TX_success = 1'b0;
  endtask

  // Drives CD for one cycle at t; returns in the COLLIDE cycle (t+1).
  task automatic cd_at(input int t);
    wait_cyc(t);
    CD = 1'b1;
    @(negedge clk);
    CD = 1'b0;
  endtask

  function automatic int backoff_cycles(input int n, input logic [15:0] l);
    int k;
    int slots;
    k     = (n > 10) ? 10 : n;
    slots = int'(l) & ((1 << k) - 1);
    return (slots == 0) ? 1 : slots * SLOT;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int w, w2, c, s;
    reset = 1'b1; IB = 1'b1; CD = 1'b0; TX_success = 1'b0;
    up_valid = 1'b0; up_last = 1'b0; up_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_up_ready", up_ready, 0);
    chk("rst_dtx", D_TX, 0);
    chk("rst_dtx_ready", D_TX_ready, 0);
    chk("rst_done_fail", {tx_done, tx_fail}, 0);
    chk("rst_busy", busy, 0);
`ifdef DLC_TX_STATS_EN
    chk("rst_stats", {frames_ok, frames_failed, collisions}, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    chk("idle_up_ready", up_ready, 1);

    // Basic 4-byte frame.
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    push_frame(4, w);
    expect_strobes(w, 4);
    wait_cyc(w + 10);
    chk("wait_ib_up_ready", up_ready, 0);
    chk("wait_ib_busy", busy, 1);
    s = w + 100;
    success_at(s + 10);
    chk("done_busy", busy, 0);

    // IFG restart: IB low at idle count 39.
    fb[0] = 8'hAA; fb[1] = 8'hBB;
    push_frame(2, w);
    q.push_back('{0, 8'hAA, w + 80});
    q.push_back('{0, 8'hBB, w + 100});
    wait_cyc(w + 39);
    IB = 1'b0;
    @(negedge clk);
    IB = 1'b1;
    success_at(w + 105);

    // Collision during byte 1 of 4, then full resend.
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
    push_frame(4, w);
    expect_strobes(w, 2);
    c = w + 70;
    cd_at(c);
    chk("collide_busy", busy, 1);
    w2 = c + 2 + backoff_cycles(1, lfsr_m);
    expect_strobes(w2, 4);
    success_at(w2 + 110);

    // Retry exhaustion from a clean reset.
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    fb[0] = 8'h5A; fb[1] = 8'hA5;
    push_frame(2, w);
    for (int a = 0; a < 16; a++) begin
      q.push_back('{0, 8'h5A, w + 40});
      c = w + 45;
      cd_at(c);
      if (a == 15) q.push_back('{2, 8'h00, c + 2});
      else         w = c + 2 + backoff_cycles(a + 1, lfsr_m);
    end
    wait_cyc(c + 2);
    chk("fail_attempt", 32'(dut.attempt), 0);
    chk("fail_busy", busy, 0);
    wait_cyc(c + 3);
`ifdef DLC_TX_STATS_EN
    chk("stat_collisions", collisions, 16);
    chk("stat_failed", frames_failed, 1);
    chk("stat_ok", frames_ok, 0);
`endif

    // Overflow: 300-byte source frame, only the first 256 are sent.
    for (int i = 0; i < 300; i++) fb[i] = 8'(i);
    ready_wait = 0;
    push_frame(300, w);
    chk("ovf_up_ready_stalls", ready_wait, 0);
    expect_strobes(w, 256);
    s = w + 40 + 20 * 255;
    success_at(s + 3);

    // CD and TX_success together in WAIT_RESULT: collision wins.
    fb[0] = 8'h77; fb[1] = 8'h88;
    push_frame(2, w);
    expect_strobes(w, 2);
    c = w + 65;
    wait_cyc(c);
    CD = 1'b1;
    TX_success = 1'b1;
    @(negedge clk);
    CD = 1'b0;
    TX_success = 1'b0;
    w2 = c + 2 + backoff_cycles(1, lfsr_m);
    expect_strobes(w2, 2);
    success_at(w2 + 65);
`ifdef DLC_TX_STATS_EN
    @(negedge clk);
    chk("stat_ok2", frames_ok, 2);
    chk("stat_collisions2", collisions, 17);
`endif

    // Reset in the middle of SEND.
    fb[0] = 8'hC1; fb[1] = 8'hC2; fb[2] = 8'hC3;
    push_frame(3, w);
    expect_strobes(w, 2);
    wait_cyc(w + 60);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_dtx_ready", D_TX_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dtx", D_TX, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fb[0] = 8'hE1; fb[1] = 8'hE2;
    push_frame(2, w);
    expect_strobes(w, 2);
    success_at(w + 70);
    wait_cyc(w + 75);
    chk("final_busy", busy, 0);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
